id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
- ID/EX pipeline boundary of the 5-stage RV32 core.
- Captures decoded control bits, from the control unit, plus operands and register indices from decode.
- Contains load-use hazard detection and generates the `stall` signal fed back to the control unit and to the IF/ID register.
- Handles branch flush, downstream hold, and keeps saturating hazard event counters for debug.

Parameters:
- XLEN, 32, datapath width (PC, operands, immediate).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_branch, id_memtoreg, id_memwrite, id_alusrc, id_regwrite  in  1 each  control unit outputs
- id_aluop  in  2  control unit ALUOp
- id_uses_rs2  in  1  instruction reads rs2 (R-type, store, branch)
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data, id_imm  in  XLEN  operands and immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3  funct3
- id_funct7b5  in  1  instr[30]
- flush  in  1  branch taken in EX; squash the decode slot
- ex_hold  in  1  downstream not ready; freeze ID/EX
- stall  out  1  freeze PC/IF-ID and zero control unit outputs
- ex_valid  out  1  EX slot valid
- ex_branch, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite  out  1 each  registered control bits
- ex_aluop  out  2  registered ALUOp
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered datapath values
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_funct3  out  3  registered funct3
- ex_funct7b5  out  1  registered instr[30]
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Behaviour:
- Reset: rst_n low clears every registered output and both counters to 0, asynchronously; the EX slot is then a bubble. `stall` is 0 in reset because it derives from ex_valid=0.
- Load-use detection is combinational from current ID/EX contents:
  - lu = ex_valid & ex_memtoreg & ex_regwrite & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (id_uses_rs2 & ex_rd == id_rs2))
- stall = ex_hold | (lu & ~flush).
- Register update on each rising edge, highest priority first:
  1. ex_hold=1: all ex_* hold their values, counters unchanged, flush ignored. Upstream keeps flush asserted until hold drops.
  2. flush=1: insert a bubble. ex_valid and all six control outputs go to 0; datapath fields are don't-care but are loaded as 0. flush_cnt increments.
  3. lu=1: insert a bubble, same as flush. stall_cnt increments. The decode instruction is held upstream and re-presented next cycle, when lu is 0 because the bubble is now in EX.
  4. Otherwise: load all id_* into ex_*. ex_valid=id_valid. Control bits are loaded gated by id_valid (id_valid=0 yields all control 0).
- Latency: one cycle from decode inputs to ex_* outputs. A load-use costs exactly one bubble.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous flush and lu: flush wins, stall_cnt does not increment, and stall is 0 so fetch redirects.
- Simultaneous hold and lu: hold wins; no bubble is inserted and no count is taken.
- x0 destination never triggers a hazard.
- The control unit maps stall=1 to all-zero controls. id_valid is still honoured independently.

Test Plan:
- Reset: drive inputs nonzero and pulse rst_n low mid-cycle -> all ex_* and counters read 0 immediately; stall=0.
- Pass-through: id_valid=1, regwrite=1, aluop=2'b10, rd=5, rs1_data=0x1234, with no hold/flush/lu -> next edge ex_rd=5, ex_aluop=2'b10, ex_rs1_data=0x1234, ex_valid=1.
- Load-use, rs2 path:
  - Setup: EX holds a load (memtoreg=1, regwrite=1, rd=7). Decode has rs2=7, uses_rs2=1.
  - Response: stall=1 the same cycle. Next edge: ex_valid=0, controls 0, stall_cnt=1.
  - Following cycle: stall=0 and the instruction loads.
  - Repeat with rd=0 -> stall=0.
- Flush beats lu: same setup as the load-use case plus flush=1 -> stall=0, bubble inserted, flush_cnt=1, stall_cnt=0.
- Hold beats flush: ex_hold=1 with flush=1 for 3 cycles -> ex_* unchanged, stall=1, counters unchanged. Release hold with flush still 1 -> bubble, flush_cnt=1.
- Saturation: CNT_W=2 with 5 consecutive flush cycles -> flush_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register of the 5-stage RV32 core.
//
// This block captures the decoded control bits, operands and register indices.
// It detects load-use hazards against the instruction currently in EX and
// inserts a single bubble for each one. It squashes the decode slot on a
// taken branch (flush) and freezes on a downstream hold (ex_hold). It also
// keeps saturating stall and flush event counters for debug.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   id_*                   decode-stage instruction (valid, controls, operands, indices)
//   flush                  squash the decode slot (branch taken in EX)
//   ex_hold                freeze the ID/EX contents
//   stall                  combinational: freeze PC/IF-ID, zero control unit outputs
//   ex_*                   registered EX-stage instruction
//   stall_cnt, flush_cnt   saturating event counters
module id_ex_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             id_valid,
    input  logic             id_branch,
    input  logic             id_memtoreg,
    input  logic             id_memwrite,
    input  logic             id_alusrc,
    input  logic             id_regwrite,
    input  logic [1:0]       id_aluop,
    input  logic             id_uses_rs2,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [2:0]       id_funct3,
    input  logic             id_funct7b5,

    input  logic             flush,
    input  logic             ex_hold,
    output logic             stall,

    output logic             ex_valid,
    output logic             ex_branch,
    output logic             ex_memtoreg,
    output logic             ex_memwrite,
    output logic             ex_alusrc,
    output logic             ex_regwrite,
    output logic [1:0]       ex_aluop,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,

    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic rd_hit_c;
    logic lu_c;

    // Load in EX whose destination is a source of the decode instruction; x0 never hazards.
    assign rd_hit_c = (ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2));
    assign lu_c     = ex_valid && ex_memtoreg && ex_regwrite && (ex_rd != 5'd0)
                      && id_valid && rd_hit_c;

    // A flush redirects fetch, so a coincident load-use must not freeze it.
    assign stall = ex_hold || (lu_c && !flush);

    // Pipeline register: hold > flush > load-use bubble > normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_regwrite <= 1'b0;
            ex_aluop    <= 2'b00;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= 5'd0;
            ex_rs2      <= 5'd0;
            ex_rd       <= 5'd0;
            ex_funct3   <= 3'd0;
            ex_funct7b5 <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else if (!ex_hold) begin
            if (flush || lu_c) begin
                // Bubble: datapath fields are dead but zeroed for a clean trace.
                ex_valid    <= 1'b0;
                ex_branch   <= 1'b0;
                ex_memtoreg <= 1'b0;
                ex_memwrite <= 1'b0;
                ex_alusrc   <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_aluop    <= 2'b00;
                ex_pc       <= '0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_imm      <= '0;
                ex_rs1      <= 5'd0;
                ex_rs2      <= 5'd0;
                ex_rd       <= 5'd0;
                ex_funct3   <= 3'd0;
                ex_funct7b5 <= 1'b0;
                if (flush) begin
                    if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
                end else begin
                    if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                // Controls are gated by id_valid so an empty slot can never write state.
                ex_valid    <= id_valid;
                ex_branch   <= id_valid & id_branch;
                ex_memtoreg <= id_valid & id_memtoreg;
                ex_memwrite <= id_valid & id_memwrite;
                ex_alusrc   <= id_valid & id_alusrc;
                ex_regwrite <= id_valid & id_regwrite;
                ex_aluop    <= id_valid ? id_aluop : 2'b00;
                ex_pc       <= id_pc;
                ex_rs1_data <= id_rs1_data;
                ex_rs2_data <= id_rs2_data;
                ex_imm      <= id_imm;
                ex_rs1      <= id_rs1;
                ex_rs2      <= id_rs2;
                ex_rd       <= id_rd;
                ex_funct3   <= id_funct3;
                ex_funct7b5 <= id_funct7b5;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: the driver pushes hand-derived expectations,
// and a monitor pops them and compares (stall mid-cycle, ex_* state after each edge).
// A second instance with CNT_W=2 checks counter saturation.
module tb_id_ex_pipe;

    typedef struct packed {
        logic        valid, br, m2r, mw, as, rw;
        logic [1:0]  aluop;
        logic        uses2;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
    } id_t;

    typedef struct packed {
        logic        valid, br, m2r, mw, as, rw;
        logic [1:0]  aluop;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        logic [15:0] scnt, fcnt;
    } ex_t;

    typedef struct {
        int  idx;
        ex_t e;
    } st_item_t;

    typedef struct {
        int   idx;
        logic s;
    } stall_item_t;

    localparam int LD = 0;
    localparam int BB = 1;
    localparam int HD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_branch, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
    logic [1:0]  id_aluop;
    logic        id_uses_rs2;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        flush, ex_hold;

    logic        stall, ex_valid, ex_branch, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
    logic [1:0]  ex_aluop;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_valid, s_branch, s_memtoreg, s_memwrite, s_alusrc, s_regwrite;
    logic [1:0]  s_aluop;
    logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [2:0]  s_funct3;
    logic        s_funct7b5;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int vidx   = 0;
    st_item_t    st_q[$];
    stall_item_t stall_q[$];
    ex_t         last_exp;

    always #5 clk = ~clk;

    id_ex_pipe #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_branch(id_branch), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_uses_rs2(id_uses_rs2), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .ex_hold(ex_hold), .stall(stall),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memtoreg(ex_memtoreg),
        .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite),
        .ex_aluop(ex_aluop), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    id_ex_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_branch(id_branch), .id_memtoreg(id_memtoreg),
        .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_aluop(id_aluop), .id_uses_rs2(id_uses_rs2), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_funct7b5(id_funct7b5), .flush(flush), .ex_hold(ex_hold), .stall(s_stall),
        .ex_valid(s_valid), .ex_branch(s_branch), .ex_memtoreg(s_memtoreg),
        .ex_memwrite(s_memwrite), .ex_alusrc(s_alusrc), .ex_regwrite(s_regwrite),
        .ex_aluop(s_aluop), .ex_pc(s_pc), .ex_rs1_data(s_rs1_data),
        .ex_rs2_data(s_rs2_data), .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2),
        .ex_rd(s_rd), .ex_funct3(s_funct3), .ex_funct7b5(s_funct7b5),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Build a decode vector; secondary fields are fixed functions of the given ones.
    function automatic id_t mk(input logic v, input logic br, input logic m2r, input logic mw,
                               input logic as, input logic rw, input logic [1:0] aluop,
                               input logic uses2, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] rs1d);
        id_t t;
        t.valid = v;  t.br = br;  t.m2r = m2r;  t.mw = mw;  t.as = as;  t.rw = rw;
        t.aluop = aluop;  t.uses2 = uses2;
        t.rs1d  = rs1d;
        t.rs2d  = ~rs1d;
        t.imm   = rs1d ^ 32'h00FF_00FF;
        t.pc    = {rs1d[15:0], 16'h0040};
        t.rs1 = rs1;  t.rs2 = rs2;  t.rd = rd;
        t.f3  = rd[2:0];
        t.f7  = rs1[0];
        return t;
    endfunction

    task automatic drive_id(input id_t v);
        id_valid = v.valid;  id_branch = v.br;  id_memtoreg = v.m2r;  id_memwrite = v.mw;
        id_alusrc = v.as;  id_regwrite = v.rw;  id_aluop = v.aluop;  id_uses_rs2 = v.uses2;
        id_pc = v.pc;  id_rs1_data = v.rs1d;  id_rs2_data = v.rs2d;  id_imm = v.imm;
        id_rs1 = v.rs1;  id_rs2 = v.rs2;  id_rd = v.rd;  id_funct3 = v.f3;  id_funct7b5 = v.f7;
    endtask

    // Apply one vector and push the hand-derived stall and post-edge EX state.
    task automatic apply(input id_t v, input logic fl, input logic hd, input logic exp_stall,
                         input int act, input int scnt, input int fcnt);
        ex_t e;
        stall_item_t si;
        st_item_t    sti;
        @(negedge clk);
        #1;
        drive_id(v);
        flush   = fl;
        ex_hold = hd;
        e = '0;
        if (act == HD) begin
            e = last_exp;
        end else if (act == LD) begin
            e.valid = v.valid;  e.br = v.valid & v.br;  e.m2r = v.valid & v.m2r;
            e.mw = v.valid & v.mw;  e.as = v.valid & v.as;  e.rw = v.valid & v.rw;
            e.aluop = v.valid ? v.aluop : 2'b00;
            e.pc = v.pc;  e.rs1d = v.rs1d;  e.rs2d = v.rs2d;  e.imm = v.imm;
            e.rs1 = v.rs1;  e.rs2 = v.rs2;  e.rd = v.rd;  e.f3 = v.f3;  e.f7 = v.f7;
        end
        e.scnt = 16'(scnt);
        e.fcnt = 16'(fcnt);
        last_exp = e;
        vidx++;
        si.idx = vidx;  si.s = exp_stall;  stall_q.push_back(si);
        sti.idx = vidx; sti.e = e;         st_q.push_back(sti);
    endtask

    function automatic logic [1:0] sat2(input logic [15:0] x);
        return (x > 16'd3) ? 2'd3 : x[1:0];
    endfunction

    // Monitor: stall checked mid-cycle after the driver has settled, state checked after the edge.
    initial begin
        stall_item_t si;
        st_item_t    sti;
        ex_t         a;
        forever begin
            @(negedge clk);
            #2;
            if (stall_q.size() > 0) begin
                si = stall_q.pop_front();
                n_vec++;
                if (stall !== si.s) begin
                    n_miss++;
                    $display("FAIL stall v%0d: got %b want %b", si.idx, stall, si.s);
                end
            end
            @(posedge clk);
            #1;
            if (st_q.size() > 0) begin
                sti = st_q.pop_front();
                a = {ex_valid, ex_branch, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
                     ex_aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                     ex_rd, ex_funct3, ex_funct7b5, stall_cnt, flush_cnt};
                n_vec++;
                if (a !== sti.e) begin
                    n_miss++;
                    $display("FAIL ex_state v%0d: got %h want %h", sti.idx, a, sti.e);
                end
                n_vec++;
                if ({s_stall_cnt, s_flush_cnt} !== {sat2(sti.e.scnt), sat2(sti.e.fcnt)}) begin
                    n_miss++;
                    $display("FAIL sat_cnt v%0d: got s=%0d f=%0d want s=%0d f=%0d", sti.idx,
                             s_stall_cnt, s_flush_cnt, sat2(sti.e.scnt), sat2(sti.e.fcnt));
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && st_q.size() > 0; i++) @(posedge clk);
        #2;
        n_vec++;
        if (st_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending want 0", st_q.size());
            st_q.delete();
            stall_q.delete();
        end
    endtask

    // Everything must read zero while rst_n is low, regardless of inputs.
    task automatic check_reset(input string tag);
        ex_t a;
        a = {ex_valid, ex_branch, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite,
             ex_aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
             ex_rd, ex_funct3, ex_funct7b5, stall_cnt, flush_cnt};
        n_vec++;
        if (a !== '0) begin
            n_miss++;
            $display("FAIL %s ex_state: got %h want 0", tag, a);
        end
        n_vec++;
        if ({s_valid, s_stall_cnt, s_flush_cnt} !== 5'd0) begin
            n_miss++;
            $display("FAIL %s sat_dut: got v=%b s=%0d f=%0d want 0", tag, s_valid,
                     s_stall_cnt, s_flush_cnt);
        end
        n_vec++;
        if (stall !== 1'b0) begin
            n_miss++;
            $display("FAIL %s stall: got %b want 0", tag, stall);
        end
    endtask

    initial begin
        id_t busy, v;
        busy = mk(1, 1, 1, 1, 1, 1, 2'b11, 1, 5, 6, 7, 32'hDEAD_BEEF);
        last_exp = '0;
        rst_n = 1'b0;
        drive_id(busy);
        flush = 1'b0;
        ex_hold = 1'b0;
        #3;
        check_reset("reset0");
        @(negedge clk);
        drive_id('0);
        rst_n = 1'b1;

        // Pass-through, then load followed by an rs2 consumer.
        apply(mk(1,0,0,0,0,1,2'b10,1, 5, 1, 2,32'h0000_1234), 0,0, 0, LD, 0,0);
        apply(mk(1,0,1,0,1,1,2'b00,0, 7, 3, 4,32'h0000_2000), 0,0, 0, LD, 0,0);
        v = mk(1,0,0,1,1,0,2'b00,1, 0, 8, 7,32'h0000_3000);
        apply(v, 0,0, 1, BB, 1,0);
        apply(v, 0,0, 0, LD, 1,0);
        // Load to x0 never hazards.
        apply(mk(1,0,1,0,1,1,2'b00,0, 0, 6, 0,32'h0000_5000), 0,0, 0, LD, 1,0);
        apply(mk(1,0,0,0,0,1,2'b10,1, 9, 0, 0,32'h0000_6000), 0,0, 0, LD, 1,0);
        // Flush beats load-use.
        apply(mk(1,0,1,0,1,1,2'b00,0, 7, 3, 4,32'h0000_7000), 0,0, 0, LD, 1,0);
        apply(mk(1,0,0,0,0,1,2'b10,1, 8, 1, 7,32'h0000_8000), 1,0, 0, BB, 1,1);
        // rs2 match ignored when the instruction does not read rs2.
        apply(mk(1,0,1,0,1,1,2'b00,0, 9, 2, 3,32'h0000_9000), 0,0, 0, LD, 1,1);
        apply(mk(1,0,0,0,0,1,2'b10,0,10, 4, 9,32'h0000_A000), 0,0, 0, LD, 1,1);
        // rs1 path load-use.
        apply(mk(1,0,1,0,1,1,2'b00,0,12, 5, 6,32'h0000_B000), 0,0, 0, LD, 1,1);
        v = mk(1,1,0,0,0,0,2'b01,1, 0,12,13,32'h0000_C000);
        apply(v, 0,0, 1, BB, 2,1);
        apply(v, 0,0, 0, LD, 2,1);
        // Hold beats flush for three cycles, then flush takes effect.
        v = mk(1,0,0,0,0,1,2'b10,1,20,21,22,32'h0000_D000);
        apply(v, 1,1, 1, HD, 2,1);
        apply(v, 1,1, 1, HD, 2,1);
        apply(v, 1,1, 1, HD, 2,1);
        apply(v, 1,0, 0, BB, 2,2);
        // Hold beats load-use.
        apply(mk(1,0,1,0,1,1,2'b00,0,14, 1, 1,32'h0000_E000), 0,0, 0, LD, 2,2);
        v = mk(1,0,0,0,0,1,2'b10,0,15,14, 0,32'h0000_F000);
        apply(v, 0,1, 1, HD, 2,2);
        apply(v, 0,0, 1, BB, 3,2);
        apply(v, 0,0, 0, LD, 3,2);
        // Invalid slot: controls gated, datapath still loaded.
        apply(mk(0,1,1,1,1,1,2'b11,1,15,15,15,32'h0000_1111), 0,0, 0, LD, 3,2);
        // An invalid decode slot never raises a hazard.
        apply(mk(1,0,1,0,1,1,2'b00,0,16, 2, 2,32'h0000_2222), 0,0, 0, LD, 3,2);
        apply(mk(0,0,0,0,0,0,2'b00,1, 0,16,16,32'h0000_3333), 0,0, 0, LD, 3,2);
        drain();

        // Asynchronous reset asserted mid-cycle with busy inputs.
        @(posedge clk);
        #3;
        drive_id(busy);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        @(negedge clk);
        drive_id('0);
        rst_n = 1'b1;

        // Consecutive flushes: the 2-bit counter saturates at 3.
        v = mk(1,0,0,0,0,1,2'b10,0, 1, 2, 3,32'h0000_4444);
        for (int k = 1; k <= 5; k++) apply(v, 1,0, 0, BB, 0,k);
        apply(v, 0,0, 0, LD, 0,5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
